// File: rtl/sound_pkg.sv
// Shared types and defaults for the Direct Sound FIFO feeder.
// ds_byte_sel picks one signed sample byte out of a packed word, byte 0 in bits [7:0].
package sound_pkg;

  localparam int DS_FIFO_DEPTH = 8;
  localparam int DS_DMA_THRESH = 4;

  typedef logic signed [7:0] ds_sample_t;
  typedef logic [31:0]       ds_word_t;
  typedef logic [1:0]        ds_byte_idx_t;

  function automatic ds_sample_t ds_byte_sel(input ds_word_t w, input ds_byte_idx_t idx);
    return ds_sample_t'(w[{idx, 3'b000} +: 8]);
  endfunction

endpackage

// File: rtl/fifo_word_ram.sv
// Word storage for the Direct Sound FIFO: synchronous write, combinational read.
// Contents are not reset; the pointer and count logic in the parent decides which words are valid.
module fifo_word_ram
  import sound_pkg::*;
#(
  parameter int DEPTH_WORDS = DS_FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  ds_word_t      i_wdata,
  input  logic [AW-1:0] i_raddr,
  output ds_word_t      o_rdata
);

  ds_word_t r_mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/direct_sound_fifo.sv
// One Direct Sound channel feeder: buffers 32-bit words, emits one byte per timer tick,
// and requests a DMA refill when a pop leaves the FIFO at or below the threshold.
module direct_sound_fifo
  import sound_pkg::*;
#(
  parameter int DEPTH_WORDS = DS_FIFO_DEPTH,
  parameter int DMA_THRESH  = DS_DMA_THRESH,
  localparam int CW = $clog2(DEPTH_WORDS + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          fifo_wr,
  input  ds_word_t      fifo_wdata,
  input  logic          fifo_clear,
  input  logic          enable,
  input  logic          timer_num,
  input  logic          tm0_overflow,
  input  logic          tm1_overflow,
  output ds_sample_t    sample_out,
  output logic          sample_strobe,
  output logic          dma_req,
  output logic [CW-1:0] word_count,
  output logic          underrun,
  output logic          overrun
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH_WORDS);
  localparam logic [CW-1:0] REQ_COUNT  = CW'(DMA_THRESH);

  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  ds_byte_idx_t  r_byte_idx;
  ds_sample_t    r_sample;
  logic          r_strobe, r_dma_req, r_underrun, r_overrun;

  logic          w_tick, w_empty, w_full, w_pop, w_wr_acc;
  logic [CW-1:0] w_count_next;
  ds_word_t      w_rdata;

  assign w_tick   = enable & (timer_num ? tm1_overflow : tm0_overflow);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_COUNT);
  assign w_pop    = w_tick & ~w_empty & (r_byte_idx == 2'd3);
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a coincident write.
  assign w_wr_acc = fifo_wr & (~w_full | w_pop);
  assign w_count_next = r_count + CW'(w_wr_acc) - CW'(w_pop);

  fifo_word_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clock   (clock),
    .i_we    (w_wr_acc & ~fifo_clear),
    .i_waddr (r_wr_ptr),
    .i_wdata (fifo_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_byte_idx <= '0;
      r_sample   <= '0;
      r_strobe   <= 1'b0;
      r_dma_req  <= 1'b0;
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_strobe   <= 1'b0;
      r_dma_req  <= 1'b0;
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
      if (fifo_clear) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_byte_idx <= '0;
        r_sample   <= '0;
      end else begin
        if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_tick) begin
          if (w_empty) begin
            r_underrun <= 1'b1;
          end else begin
            r_sample   <= ds_byte_sel(w_rdata, r_byte_idx);
            r_strobe   <= 1'b1;
            r_byte_idx <= r_byte_idx + 1'b1;
          end
        end
        if (w_pop) begin
          r_rd_ptr  <= r_rd_ptr + 1'b1;
          r_dma_req <= (w_count_next <= REQ_COUNT);
        end
        r_overrun <= fifo_wr & w_full & ~w_pop;
        r_count   <= w_count_next;
      end
    end
  end

  assign sample_out    = r_sample;
  assign sample_strobe = r_strobe;
  assign dma_req       = r_dma_req;
  assign word_count    = r_count;
  assign underrun      = r_underrun;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_direct_sound_fifo.sv
// Self-checking bench for direct_sound_fifo: a queue-of-words model predicts every
// registered output each cycle; directed scenarios add literal expectations.
module tb_direct_sound_fifo;
  import sound_pkg::*;

  localparam int DEPTH  = 8;
  localparam int THRESH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        fifo_wr, fifo_clear, enable, timer_num, tm0_overflow, tm1_overflow;
  logic [31:0] fifo_wdata;
  logic [7:0]  sample_out;
  logic        sample_strobe, dma_req, underrun, overrun;
  logic [3:0]  word_count;

  direct_sound_fifo #(.DEPTH_WORDS(DEPTH), .DMA_THRESH(THRESH)) dut (
    .clock         (clock),
    .reset         (reset),
    .fifo_wr       (fifo_wr),
    .fifo_wdata    (fifo_wdata),
    .fifo_clear    (fifo_clear),
    .enable        (enable),
    .timer_num     (timer_num),
    .tm0_overflow  (tm0_overflow),
    .tm1_overflow  (tm1_overflow),
    .sample_out    (sample_out),
    .sample_strobe (sample_strobe),
    .dma_req       (dma_req),
    .word_count    (word_count),
    .underrun      (underrun),
    .overrun       (overrun)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: words held, byte position within the head word, last sample.
  logic [31:0] m_q[$];
  int          m_bidx = 0;
  logic [7:0]  m_sample = 8'h00;
  logic        m_strobe = 1'b0, m_dma = 1'b0, m_und = 1'b0, m_ovr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_bidx = 0; m_sample = 8'h00;
    m_strobe = 1'b0; m_dma = 1'b0; m_und = 1'b0; m_ovr = 1'b0;
  endtask

  // Predict the outputs from the inputs applied this cycle, clock once, compare.
  task automatic cycle();
    bit tick, pop;
    tick = enable && (timer_num ? tm1_overflow : tm0_overflow);
    pop = 1'b0;
    m_strobe = 1'b0; m_dma = 1'b0; m_und = 1'b0; m_ovr = 1'b0;
    if (fifo_clear) begin
      m_q.delete();
      m_bidx = 0;
      m_sample = 8'h00;
    end else begin
      if (tick) begin
        if (m_q.size() == 0) begin
          m_und = 1'b1;
        end else begin
          m_sample = 8'(m_q[0] >> (8 * m_bidx));
          m_strobe = 1'b1;
          if (m_bidx == 3) begin pop = 1'b1; m_bidx = 0; end
          else m_bidx++;
        end
      end
      if (pop) void'(m_q.pop_front());
      if (fifo_wr) begin
        if (m_q.size() < DEPTH) m_q.push_back(fifo_wdata);
        else m_ovr = 1'b1;
      end
      if (pop) m_dma = (m_q.size() <= THRESH);
    end
    @(posedge clock);
    #1;
    chk("sample_out", 32'(sample_out), 32'(m_sample));
    chk("sample_strobe", 32'(sample_strobe), 32'(m_strobe));
    chk("dma_req", 32'(dma_req), 32'(m_dma));
    chk("underrun", 32'(underrun), 32'(m_und));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("word_count", 32'(word_count), 32'(m_q.size()));
  endtask

  task automatic idle_inputs();
    fifo_wr = 1'b0; fifo_clear = 1'b0; tm0_overflow = 1'b0; tm1_overflow = 1'b0;
  endtask

  task automatic wr(input logic [31:0] w);
    fifo_wdata = w; fifo_wr = 1'b1;
    cycle();
    fifo_wr = 1'b0;
    $display("write %08h -> count %0d overrun %0b", w, word_count, overrun);
  endtask

  task automatic tk();
    if (timer_num) tm1_overflow = 1'b1; else tm0_overflow = 1'b1;
    cycle();
    tm0_overflow = 1'b0; tm1_overflow = 1'b0;
    $display("tick -> sample %02h strobe %0b dma %0b underrun %0b count %0d",
             sample_out, sample_strobe, dma_req, underrun, word_count);
  endtask

  task automatic clr();
    fifo_clear = 1'b1;
    cycle();
    fifo_clear = 1'b0;
    $display("clear -> count %0d sample %02h", word_count, sample_out);
  endtask

  initial begin
    logic [31:0] words [DEPTH];
    reset = 1'b0; enable = 1'b1; timer_num = 1'b0; fifo_wdata = '0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset sample_out", 32'(sample_out), 32'h0);
    chk("reset word_count", 32'(word_count), 32'h0);
    chk("reset pulses", {28'h0, sample_strobe, dma_req, underrun, overrun}, 32'h0);
    reset = 1'b1;

    // 1: byte order and strobe latency
    wr(32'h44332211);
    tk(); chk("t1 byte0", 32'(sample_out), 32'h11); chk("t1 strobe0", 32'(sample_strobe), 32'h1);
    tk(); chk("t1 byte1", 32'(sample_out), 32'h22);
    tk(); chk("t1 byte2", 32'(sample_out), 32'h33);
    tk(); chk("t1 byte3", 32'(sample_out), 32'h44);
    chk("t1 count", 32'(word_count), 32'h0);
    chk("t1 dma", 32'(dma_req), 32'h1);

    // 2: fill, overflow write dropped, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      words[i] = $urandom;
      wr(words[i]);
    end
    wr(32'hDEADBEEF);
    chk("t2 overrun", 32'(overrun), 32'h1);
    chk("t2 count", 32'(word_count), 32'h8);
    for (int i = 0; i < 4 * DEPTH; i++) tk();
    chk("t2 last byte", 32'(sample_out), 32'(words[DEPTH-1][31:24]));
    chk("t2 drained", 32'(word_count), 32'h0);

    // 3: DMA request only on pops leaving <= 4 words
    for (int i = 0; i < DEPTH; i++) wr($urandom);
    for (int i = 0; i < 16; i++) begin
      tk();
      if ((i % 4) == 3)
        chk("t3 dma at pop", 32'(dma_req), ((DEPTH - (i + 1) / 4) <= THRESH) ? 32'h1 : 32'h0);
    end
    for (int i = 0; i < 16; i++) tk();

    // 4: underrun holds last sample
    wr(32'h7F000000);
    for (int i = 0; i < 4; i++) tk();
    chk("t4 last sample", 32'(sample_out), 32'h7F);
    tk();
    chk("t4 underrun", 32'(underrun), 32'h1);
    chk("t4 hold", 32'(sample_out), 32'h7F);
    chk("t4 no strobe", 32'(sample_strobe), 32'h0);

    // 5: clear beats a coincident write and tick
    for (int i = 0; i < 3; i++) wr($urandom);
    tk(); tk();
    fifo_clear = 1'b1; fifo_wr = 1'b1; fifo_wdata = 32'h55555555; tm0_overflow = 1'b1;
    cycle();
    idle_inputs();
    chk("t5 count", 32'(word_count), 32'h0);
    chk("t5 sample", 32'(sample_out), 32'h0);
    chk("t5 no strobe", 32'(sample_strobe), 32'h0);
    chk("t5 no overrun", 32'(overrun), 32'h0);
    wr(32'hA1B2C3D4);
    tk();
    chk("t5 restart byte0", 32'(sample_out), 32'hD4);

    // 6: timer select and enable gating
    clr();
    wr(32'h0D0C0B0A);
    timer_num = 1'b1;
    tk();
    chk("t6 tm1 byte0", 32'(sample_out), 32'h0A);
    tm0_overflow = 1'b1; cycle(); tm0_overflow = 1'b0;
    chk("t6 tm0 ignored", 32'(sample_strobe), 32'h0);
    chk("t6 tm0 hold", 32'(sample_out), 32'h0A);
    tk();
    chk("t6 tm1 byte1", 32'(sample_out), 32'h0B);
    enable = 1'b0;
    tk();
    chk("t6 disabled", 32'(sample_strobe), 32'h0);
    chk("t6 disabled hold", 32'(sample_out), 32'h0B);
    enable = 1'b1; timer_num = 1'b0;
    clr();

    // Randomised phases alternating fill-heavy and drain-heavy traffic
    for (int blk = 0; blk < 30; blk++) begin
      for (int c = 0; c < 60; c++) begin
        fifo_wr      = ($urandom_range(99) < ((blk % 2) ? 25 : 70));
        fifo_wdata   = $urandom;
        fifo_clear   = ($urandom_range(199) == 0);
        enable       = ($urandom_range(9) != 0);
        timer_num    = 1'($urandom_range(1));
        tm0_overflow = ($urandom_range(99) < ((blk % 2) ? 70 : 25));
        tm1_overflow = ($urandom_range(99) < ((blk % 2) ? 70 : 25));
        cycle();
      end
      $display("random block %0d -> count %0d sample %02h", blk, word_count, sample_out);
    end
    idle_inputs();
    enable = 1'b1; timer_num = 1'b0;

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) wr($urandom);
    tk();
    reset = 1'b0;
    #2;
    chk("async reset count", 32'(word_count), 32'h0);
    chk("async reset sample", 32'(sample_out), 32'h0);
    chk("async reset pulses", {28'h0, sample_strobe, dma_req, underrun, overrun}, 32'h0);
    model_reset();
    #1 reset = 1'b1;
    wr(32'h04030201);
    tk();
    chk("post reset byte0", 32'(sample_out), 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
